// File: rtl/symcounter_pkg.sv
// Shared types and default timing constants for the SymCounter game flow.
package symcounter_pkg;

  typedef logic [3:0] level_t;
  typedef logic [3:0] secs_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PLAY,
    POST_REQ,
    POST_WAIT,
    DONE
  } seq_state_t;

  localparam int PRE_SECS  = 3;
  localparam int PLAY_SECS = 10;
  localparam int MAX_LEVEL = 8;

endpackage

// File: rtl/level_sequencer_if.sv
// Player/post-period handshake bundle between level_sequencer and its peers.
// The sequencer is the master: it starts the post period and consumes the rest.
interface level_sequencer_if;
  logic startBtn;
  logic answerValid;
  logic answerCorrect;
  logic levelComplete;
  logic postSig;

  modport master (
    input  startBtn, answerValid, answerCorrect, levelComplete,
    output postSig
  );

  modport slave (
    output startBtn, answerValid, answerCorrect, levelComplete,
    input  postSig
  );
endinterface

// File: rtl/level_sequencer_tick_countdown.sv
// Loadable down-counter advanced by the 1 Hz tick. A load in the same cycle
// as a tick wins, so the tick that coincides with a load is never counted.
// expire flags the tick that takes the count from 1 to 0.
module tick_countdown
  import symcounter_pkg::*;
(
  input  logic  Clk100M,
  input  logic  Reset_n,
  input  logic  load,
  input  secs_t loadVal,
  input  logic  tick,
  output secs_t count,
  output logic  expire
);

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge Clk100M) begin
    if (!Reset_n)
      count <= '0;
    else if (load)
      count <= loadVal;
    else if (tick && (count != '0))
      count <= count - 1'b1;
  end

  assign expire = tick && (count == secs_t'(1));

endmodule

// File: rtl/level_sequencer.sv
// Per-level game flow: PRE countdown, timed PLAY, then the post-period
// handshake (postSig out, levelComplete back), advancing or ending the game.
// Optional feature macro: LEVEL_TIMEOUT_EN adds a POST_WAIT tick watchdog.
module level_sequencer
  import symcounter_pkg::*;
#(
  parameter int PRE_SECS     = symcounter_pkg::PRE_SECS,
  parameter int PLAY_SECS    = symcounter_pkg::PLAY_SECS,
  parameter int MAX_LEVEL    = symcounter_pkg::MAX_LEVEL,
  parameter int POST_TIMEOUT = 15
) (
  input  logic                     Clk100M,
  input  logic                     Reset_n,
  input  logic                     Clk1Hz,
  level_sequencer_if.master        bus,
  output level_t                   level,
  output secs_t                    timeLeft,
  output logic                     preActive,
  output logic                     playActive,
  output logic                     lastCorrect,
  output logic                     gameOver,
  output logic                     gameWon
);

  localparam level_t LastLevel = level_t'(MAX_LEVEL - 1);

  seq_state_t state, stateNext;
  level_t     levelNext;
  logic       lastNext;
  logic       wonNext;
  logic       cntLoad;
  secs_t      cntLoadVal;
  logic       cntTick;
  logic       cntExpire;
  logic       earlyDone;
  logic       wdExpire;
  logic       handshake;

  // An answer in PLAY discards a coincident tick.
  assign cntTick = Clk1Hz && ((state == PRE) || ((state == PLAY) && !bus.answerValid));

  tick_countdown uCount (
    .Clk100M (Clk100M),
    .Reset_n (Reset_n),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .tick    (cntTick),
    .count   (timeLeft),
    .expire  (cntExpire)
  );

`ifdef LEVEL_TIMEOUT_EN
  secs_t wdCount;
  logic  wdFire;

  tick_countdown uWatchdog (
    .Clk100M (Clk100M),
    .Reset_n (Reset_n),
    .load    (state == POST_REQ),
    .loadVal (secs_t'(POST_TIMEOUT)),
    .tick    (Clk1Hz && (state == POST_WAIT)),
    .count   (wdCount),
    .expire  (wdFire)
  );

  assign wdExpire = wdFire && (wdCount != '0);
`else
  // Without the watchdog POST_WAIT never gives up; POST_TIMEOUT has no effect.
  assign wdExpire = 1'b0 && (POST_TIMEOUT > 0);
`endif

  // levelComplete seen during POST_REQ is remembered for the first POST_WAIT cycle.
  assign handshake = bus.levelComplete || earlyDone || wdExpire;

  // Next-state and next-value logic for the level flow.
  always_comb begin
    stateNext  = state;
    levelNext  = level;
    lastNext   = lastCorrect;
    wonNext    = gameWon;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.startBtn) begin
          levelNext  = '0;
          wonNext    = 1'b0;
          cntLoad    = 1'b1;
          cntLoadVal = secs_t'(PRE_SECS);
          stateNext  = PRE;
        end
      end
      PRE: begin
        if (cntExpire) begin
          cntLoad    = 1'b1;
          cntLoadVal = secs_t'(PLAY_SECS);
          stateNext  = PLAY;
        end
      end
      PLAY: begin
        if (bus.answerValid) begin
          lastNext  = bus.answerCorrect;
          cntLoad   = 1'b1;
          stateNext = POST_REQ;
        end else if (cntExpire) begin
          lastNext  = 1'b0;
          stateNext = POST_REQ;
        end
      end
      POST_REQ: stateNext = POST_WAIT;
      POST_WAIT: begin
        if (handshake) begin
          if (lastCorrect && (level != LastLevel)) begin
            levelNext  = level + 1'b1;
            cntLoad    = 1'b1;
            cntLoadVal = secs_t'(PRE_SECS);
            stateNext  = PRE;
          end else begin
            wonNext   = lastCorrect;
            stateNext = DONE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State plus registered outputs decoded from the next state.
  always_ff @(posedge Clk100M) begin
    if (!Reset_n) begin
      state       <= IDLE;
      level       <= '0;
      lastCorrect <= 1'b0;
      gameWon     <= 1'b0;
      gameOver    <= 1'b0;
      preActive   <= 1'b0;
      playActive  <= 1'b0;
      bus.postSig <= 1'b0;
      earlyDone   <= 1'b0;
    end else begin
      state       <= stateNext;
      level       <= levelNext;
      lastCorrect <= lastNext;
      gameWon     <= wonNext;
      gameOver    <= (stateNext == DONE);
      preActive   <= (stateNext == PRE);
      playActive  <= (stateNext == PLAY);
      bus.postSig <= (stateNext == POST_REQ);
      earlyDone   <= (state == POST_REQ) && bus.levelComplete;
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Randomised game-flow bench: a driver plays whole games against a
// level-by-level model and queues the expected post-period starts; a monitor
// pops one entry per postSig pulse and checks level, result and timing.
module tb_level_sequencer;

  localparam int PreSecs     = 3;
  localparam int PlaySecs    = 10;
  localparam int MaxLevel    = 8;
  localparam int PostTimeout = 15;

  logic       Clk100M = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Clk1Hz  = 1'b0;
  logic [3:0] level, timeLeft;
  logic       preActive, playActive, lastCorrect, gameOver, gameWon;

  level_sequencer_if bus();

  level_sequencer dut (
    .Clk100M     (Clk100M),
    .Reset_n     (Reset_n),
    .Clk1Hz      (Clk1Hz),
    .bus         (bus),
    .level       (level),
    .timeLeft    (timeLeft),
    .preActive   (preActive),
    .playActive  (playActive),
    .lastCorrect (lastCorrect),
    .gameOver    (gameOver),
    .gameWon     (gameWon)
  );

  always #5 Clk100M = ~Clk100M;

  int cyc = 0;
  always @(posedge Clk100M) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int postCount = 0;

  typedef struct {
    int lvl;
    int lc;
    int at;
  } post_t;
  post_t expQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every postSig pulse must match the oldest queued expectation.
  always @(negedge Clk100M) begin
    post_t e;
    if (bus.postSig === 1'b1) begin
      postCount++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL post_unexpected: postSig at cycle %0d with level %0d, none expected", cyc, level);
      end else begin
        e = expQ.pop_front();
        chk("post_level", level, e.lvl);
        chk("post_last", lastCorrect, e.lc);
        chk("post_cycle", cyc, e.at);
        chk("post_time", timeLeft, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench stuck at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic drive(input logic sb, input logic tk, input logic av, input logic ac, input logic lc);
    bus.startBtn      = sb;
    Clk1Hz            = tk;
    bus.answerValid   = av;
    bus.answerCorrect = ac;
    bus.levelComplete = lc;
    @(posedge Clk100M);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_time"}, timeLeft, 0);
    chk({tag, "_pre"}, preActive, 0);
    chk({tag, "_play"}, playActive, 0);
    chk({tag, "_last"}, lastCorrect, 0);
    chk({tag, "_over"}, gameOver, 0);
    chk({tag, "_won"}, gameWon, 0);
    chk({tag, "_post"}, bus.postSig, 0);
  endtask

  task automatic chk_waiting(input string tag);
    chk({tag, "_pre"}, preActive, 0);
    chk({tag, "_play"}, playActive, 0);
    chk({tag, "_over"}, gameOver, 0);
    chk({tag, "_post"}, bus.postSig, 0);
  endtask

  // mode: 0 random, 1 full win, 2 timeout at level 0, 3 reset in POST_WAIT at level 3, 4 watchdog at level 0
  task automatic play_game(input int mode);
    int   lvl, ticks, ansAt, d, wt, postAt;
    logic tk, av, correct, timeout, early, expLc;
    bit   fin, decided;
    lvl = 0;
    fin = 0;
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    chk("start_pre", preActive, 1);
    chk("start_level", level, 0);
    chk("start_time", timeLeft, PreSecs);
    chk("start_over", gameOver, 0);
    chk("start_won", gameWon, 0);
    while (!fin) begin
      ticks = 0;
      while (ticks < PreSecs) begin
        tk = ($urandom_range(0, 2) == 0);
        drive(($urandom_range(0, 7) == 0), tk, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        if (tk) ticks++;
        if (ticks < PreSecs) chk("pre_time", timeLeft, PreSecs - ticks);
      end
      chk("play_enter", playActive, 1);
      chk("play_enter_pre", preActive, 0);
      chk("play_time0", timeLeft, PlaySecs);

      timeout = (mode == 2 && lvl == 0) || (mode == 0 && $urandom_range(0, 4) == 0);
      correct = (mode == 1 || mode == 3) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 5) != 0);
      early   = (mode != 4) && ($urandom_range(0, 3) == 0);
      ansAt   = $urandom_range(0, PlaySecs - 1);
      ticks   = 0;
      expLc   = 1'b0;
      decided = 0;
      while (!decided) begin
        tk = ($urandom_range(0, 2) == 0);
        av = !timeout && (ticks >= ansAt) && ($urandom_range(0, 1) == 0);
        if (!timeout && tk && ticks == PlaySecs - 1) av = 1'b1;
        drive(($urandom_range(0, 7) == 0), tk, av, av ? correct : 1'($urandom_range(0, 1)), early);
        if (av) begin
          expLc   = correct;
          decided = 1;
        end else if (tk) begin
          ticks++;
          if (ticks == PlaySecs) decided = 1;
          else chk("play_time", timeLeft, PlaySecs - ticks);
        end
      end
      postAt = cyc;
      expQ.push_back('{lvl, int'(expLc), postAt});
      chk("req_last", lastCorrect, expLc);
      chk("req_time", timeLeft, 0);
      chk("req_play", playActive, 0);

      if (mode == 3 && lvl == 3) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_waiting("rst_wait");
        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        chk_all_zero("rst_mid");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_all_zero("rst_idle");
        return;
      end

      if (mode == 4 && lvl == 0) begin
`ifdef LEVEL_TIMEOUT_EN
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wt = 0;
        while (wt < PostTimeout) begin
          tk = 1'($urandom_range(0, 1));
          drive(1'b0, tk, 1'b0, 1'b0, 1'b0);
          if (tk) wt++;
          if (wt < PostTimeout) chk_waiting("wd_wait");
        end
`else
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_waiting("wd_none");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      end else if (early) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_waiting("early_wait");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        d = $urandom_range(0, 5);
        if (d == 0) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          chk_waiting("pulse_wait");
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
          for (int i = 1; i < d; i++) begin
            chk_waiting("post_wait");
            drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
          end
          chk_waiting("post_wait");
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end

      if (expLc && lvl < MaxLevel - 1) begin
        lvl++;
        chk("next_pre", preActive, 1);
        chk("next_level", level, lvl);
        chk("next_time", timeLeft, PreSecs);
      end else begin
        chk("done_over", gameOver, 1);
        chk("done_won", gameWon, expLc);
        chk("done_level", level, lvl);
        chk("done_pre", preActive, 0);
        chk("done_time", timeLeft, 0);
        for (int i = 0; i < 4; i++)
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("hold_over", gameOver, 1);
        chk("hold_won", gameWon, expLc);
        chk("hold_level", level, lvl);
        fin = 1;
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all_zero("rst_init");
    Reset_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all_zero("idle_hold");

    play_game(1);
    chk("win_posts", postCount, MaxLevel);
    chk("win_won", gameWon, 1);
    play_game(2);
    play_game(3);
    play_game(4);
    for (int g = 0; g < 5; g++) play_game(0);

    @(negedge Clk100M);
    chk("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller for SymCounter. It runs the per-level sequence: pre-period countdown, timed play period, then the post-period handshake. It is the initiator for the post-period display block: it issues the one-cycle `postSig` start pulse, waits for `levelComplete`, then advances the level or ends the game. It sits between the input/answer logic and the display blocks, in the `Clk100M` domain.

## Interface
- `PRE_SECS`, 3, pre-period countdown length in `Clk1Hz` ticks (1..15)
- `PLAY_SECS`, 10, play-period length in ticks (1..15)
- `MAX_LEVEL`, 8, number of levels (2..16)
- `POST_TIMEOUT`, 15, watchdog limit in ticks while waiting for `levelComplete` (used only with `LEVEL_TIMEOUT_EN`)

- `Clk100M` in 1, system clock; single clock domain
- `Reset_n` in 1, synchronous, active-low reset
- `Clk1Hz` in 1, one-`Clk100M`-cycle tick pulse
- `startBtn` in 1, debounced one-cycle start pulse
- `answerValid` in 1, one-cycle pulse: the player submitted an answer
- `answerCorrect` in 1, qualifies `answerValid`
- `levelComplete` in 1, post-period finished; sampled as a level
- `postSig` out 1, one-cycle pulse that starts the post period
- `level` out 4, current level, 0-based
- `timeLeft` out 4, seconds remaining in PRE/PLAY; 0 otherwise
- `preActive` out 1, high in PRE
- `playActive` out 1, high in PLAY
- `lastCorrect` out 1, result of the most recent level; valid from POST_REQ onward
- `gameOver` out 1, high in DONE
- `gameWon` out 1, high in DONE if all levels were passed

## Operation
- States: IDLE, PRE, PLAY, POST_REQ, POST_WAIT, DONE.
- **IDLE**
  - On `startBtn`: set `level`=0 and `timeLeft`=PRE_SECS, then go to PRE.
- **PRE**
  - Each tick decrements `timeLeft`.
  - A tick when `timeLeft`=1 sets `timeLeft`=PLAY_SECS and goes to PLAY.
  - `answerValid` is ignored.
- **PLAY**
  - `answerValid` latches `lastCorrect`=`answerCorrect`, then goes to POST_REQ.
  - Otherwise a tick decrements `timeLeft`.
  - A tick when `timeLeft`=1 sets `lastCorrect`=0 and goes to POST_REQ.
  - `answerValid` and a tick in the same cycle: the answer wins and the tick is discarded.
- **POST_REQ**
  - Lasts exactly one cycle with `postSig`=1, then goes to POST_WAIT.
  - `timeLeft`=0 from here.
- **POST_WAIT**
  - Waits for `levelComplete`=1. Then:
    - if `lastCorrect` and `level`<MAX_LEVEL-1: `level`+1, `timeLeft`=PRE_SECS, go to PRE;
    - if `lastCorrect` and `level`=MAX_LEVEL-1: `gameWon`=1, go to DONE;
    - if not `lastCorrect`: `gameWon`=0, go to DONE.
  - `levelComplete` is also honoured if it is high in the POST_REQ cycle; the transition then happens the cycle after.
- **DONE**
  - `gameOver`=1. Outputs hold.
  - `startBtn` restarts exactly as from IDLE and clears `gameOver`/`gameWon`.
- `startBtn` is ignored outside IDLE and DONE.
- All arithmetic is unsigned 4-bit. `level` never wraps past MAX_LEVEL-1.

## Timing
- Every output is registered. Reset values: state IDLE and every output 0.
- `Reset_n` low on any edge, mid-operation included, returns to IDLE on the next edge. A `postSig` in flight is dropped.
- `postSig` is high for exactly one cycle per level: one cycle after the decisive answer or tick.
- Latencies:
  - `startBtn` to `preActive`: 1 cycle.
  - Final PRE tick to `playActive`: 1 cycle.
  - `levelComplete` to next state: 1 cycle.
- PRE lasts exactly PRE_SECS ticks. An unanswered PLAY lasts exactly PLAY_SECS ticks.
- A tick in the cycle the block enters PRE/PLAY is not counted; counting starts the following cycle.

## Configuration
- `LEVEL_TIMEOUT_EN` defined:
  - POST_WAIT counts ticks.
  - After POST_TIMEOUT ticks without `levelComplete`, it proceeds as if `levelComplete` were received.
  - The counter clears on entry to POST_WAIT.
- Not defined: POST_WAIT waits indefinitely and no counter is present.

## Structure
- Shared package `symcounter_pkg` holds:
  - the state enum;
  - the 4-bit `level_t`/`secs_t` typedefs;
  - the default constants PRE_SECS, PLAY_SECS, MAX_LEVEL.
- One sub-module, `tick_countdown`:
  - load value, `Clk1Hz` enable, `expire` pulse on the 1→0 tick;
  - reused for PRE, PLAY and the optional watchdog.

## Test plan
- **Full win:** `startBtn`, 3 ticks, `answerValid`+`answerCorrect` each level, `levelComplete` 5 cycles after each `postSig`, with MAX_LEVEL=8 -> 8 `postSig` pulses; `level` steps 0..7; then `gameOver`=1, `gameWon`=1.
- **Play timeout:** no answer for 10 ticks -> `postSig` 1 cycle after the 10th tick, `lastCorrect`=0; after `levelComplete`, `gameOver`=1, `gameWon`=0.
- **Simultaneous:** `answerValid`(correct) and `Clk1Hz` in the same cycle with `timeLeft`=1 -> `lastCorrect`=1, one `postSig`, no timeout path taken.
- **Early handshake:** `levelComplete` held high from before `postSig` -> PRE entered 2 cycles after `postSig`; no second `postSig`.
- **Reset:** `Reset_n`=0 for one cycle during POST_WAIT at level 3 -> next cycle all outputs 0, state IDLE; `startBtn` restarts at `level`=0.
- **Watchdog:** with `LEVEL_TIMEOUT_EN`, `levelComplete` never asserted -> exit POST_WAIT after exactly 15 ticks. Without the macro -> still in POST_WAIT after 30 ticks.
